register: RTL and testbench

REGISTER -- requirements
Module: register

---
 rtl/register_pkg.sv | 16 +
 rtl/reg_stack.sv | 48 ++++
 rtl/register.sv | 77 +++++++
 tb/tb_register.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/register_pkg.sv
// Shared sizing for the register file and its hardware stack.
// Defaults and the stack-pointer width helper live here.
package register_pkg;

  localparam int DATA_W_DEF      = 16;
  localparam int NUM_REGS_DEF    = 16;
  localparam int STACK_DEPTH_DEF = 16;

  // sp spans 0..depth inclusive, so it needs one extra code point
  function automatic int sp_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int SP_W = sp_width(STACK_DEPTH_DEF);

endpackage

// File: rtl/reg_stack.sv
// LIFO stack of data words with a saturating occupancy pointer.
// Push and pop are already qualified by the caller; full/empty gate them.
module reg_stack
  import register_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = STACK_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] top_data,
  output logic              full,
  output logic              empty
);

  localparam int SPW = sp_width(DEPTH);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] stack [DEPTH];
  logic [SPW-1:0]    sp;
  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     rd_idx;

  assign full   = (sp == SPW'(DEPTH));
  assign empty  = (sp == '0);
  assign wr_idx = AW'(sp);
  assign rd_idx = AW'(sp - 1'b1);

  assign top_data = stack[rd_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        stack[i] <= '0;
      end
    end else if (push && !full) begin
      stack[wr_idx] <= push_data;
      sp            <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end
  end

endmodule

// File: rtl/register.sv
// General register file with a hardware stack for save/restore.
// Stack mode overrides plain reads and writes.
module register
  import register_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int NUM_REGS    = NUM_REGS_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wn,
  input  logic              stack_en,
  input  logic              push_en,
  input  logic              pop_en,
  input  logic [3:0]        reg_id,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] top_data;
  logic              full;
  logic              empty;
  logic              push_req;
  logic              pop_req;
  logic              do_push;
  logic              do_pop;
  logic              do_wr;
  logic              do_rd;

  // AND with stack_en first so X on push/pop is masked in register mode
  assign push_req = stack_en & push_en & ~pop_en;
  assign pop_req  = stack_en & pop_en & ~push_en;
  assign do_push  = push_req & ~full;
  assign do_pop   = pop_req & ~empty;
  assign do_wr    = ~stack_en & wn;
  assign do_rd    = ~stack_en & rd;

  reg_stack #(
    .DATA_W (DATA_W),
    .DEPTH  (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (do_push),
    .pop       (do_pop),
    .push_data (regs[reg_id]),
    .top_data  (top_data),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (do_pop) begin
      regs[reg_id] <= top_data;
    end else if (do_wr) begin
      regs[reg_id] <= write_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data <= '0;
    end else if (do_pop) begin
      read_data <= top_data;
    end else if (do_rd) begin
      read_data <= regs[reg_id];
    end
  end

endmodule

// File: tb/tb_register.sv
// Directed bench for the register file and stack.
// Observes read_data only; stack depth is inferred via pops.
module tb_register;

  logic        clk;
  logic        reset;
  logic        rd;
  logic        wn;
  logic        stack_en;
  logic        push_en;
  logic        pop_en;
  logic [3:0]  reg_id;
  logic [15:0] write_data;
  logic [15:0] read_data;

  int checks;
  int errors;

  register dut (
    .clk        (clk),
    .reset      (reset),
    .rd         (rd),
    .wn         (wn),
    .stack_en   (stack_en),
    .push_en    (push_en),
    .pop_en     (pop_en),
    .reg_id     (reg_id),
    .write_data (write_data),
    .read_data  (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    rd = 0; wn = 0; stack_en = 0;
    push_en = 0; pop_en = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input logic [3:0] id, input logic [15:0] d);
    idle();
    wn = 1; reg_id = id; write_data = d;
    push_en = 1'bx; pop_en = 1'bx;
    tick();
  endtask

  task automatic rdr(input logic [3:0] id);
    idle();
    rd = 1; reg_id = id;
    tick();
  endtask

  task automatic push(input logic [3:0] id);
    idle();
    stack_en = 1; push_en = 1; reg_id = id;
    tick();
  endtask

  task automatic pop(input logic [3:0] id);
    idle();
    stack_en = 1; pop_en = 1; reg_id = id;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    reg_id = 0;
    write_data = 0;
    reset = 0;
    #1 reset = 1;
    #1 check("reset_rd", read_data, 16'd0);
    @(negedge clk);
    reset = 0;
    #1;

    // basic write then read
    wr(4'd2, 16'd15);
    rdr(4'd2);
    check("wr_rd", read_data, 16'd15);
    tick();
    check("hold", read_data, 16'd15);

    // simultaneous write is not forwarded
    idle();
    rd = 1; wn = 1; reg_id = 3; write_data = 16'd5;
    tick();
    check("no_fwd", read_data, 16'd0);
    rdr(4'd3);
    check("wr_seen", read_data, 16'd5);

    // push/pop round trip
    push(4'd2);
    wr(4'd2, 16'd7);
    rdr(4'd2);
    check("overwrite", read_data, 16'd7);
    pop(4'd2);
    check("pop_rd", read_data, 16'd15);
    rdr(4'd2);
    check("pop_reg", read_data, 16'd15);
    rdr(4'd3);
    pop(4'd2);
    check("pop_empty", read_data, 16'd5);
    rdr(4'd2);
    check("empty_reg", read_data, 16'd15);

    // LIFO order
    wr(4'd1, 16'd1);
    wr(4'd2, 16'd2);
    wr(4'd3, 16'd3);
    push(4'd1);
    push(4'd2);
    push(4'd3);
    pop(4'd5);
    check("lifo0", read_data, 16'd3);
    pop(4'd5);
    check("lifo1", read_data, 16'd2);
    pop(4'd5);
    check("lifo2", read_data, 16'd1);
    rdr(4'd5);
    check("lifo_reg", read_data, 16'd1);

    // stack mode overrides rd/wn
    idle();
    stack_en = 1; wn = 1; rd = 1;
    reg_id = 4; write_data = 16'd99;
    tick();
    check("ovr_rd", read_data, 16'd1);
    rdr(4'd4);
    check("ovr_wr", read_data, 16'd0);

    // push and pop together is a no-op
    push(4'd1);
    rdr(4'd3);
    idle();
    stack_en = 1; push_en = 1; pop_en = 1; reg_id = 6;
    tick();
    check("both_rd", read_data, 16'd3);
    rdr(4'd6);
    check("both_reg", read_data, 16'd0);
    idle();
    stack_en = 1; reg_id = 6;
    tick();
    check("none_rd", read_data, 16'd0);
    pop(4'd7);
    check("both_sp", read_data, 16'd1);
    rdr(4'd3);
    pop(4'd7);
    check("both_empty", read_data, 16'd3);

    // fill to capacity; the 17th push must be dropped
    for (int i = 0; i < 16; i++) begin
      wr(4'(i), 16'(100 + i));
    end
    for (int i = 0; i < 16; i++) begin
      push(4'(i));
    end
    wr(4'd0, 16'd500);
    push(4'd0);
    for (int i = 15; i >= 0; i--) begin
      pop(4'd8);
      check($sformatf("full%0d", i), read_data, 16'(100 + i));
    end
    rdr(4'd9);
    pop(4'd8);
    check("drain_empty", read_data, 16'd109);

    // asynchronous reset between edges
    wr(4'd2, 16'd42);
    push(4'd2);
    rdr(4'd2);
    check("pre_rst", read_data, 16'd42);
    idle();
    wn = 1; reg_id = 2; write_data = 16'd77;
    #2 reset = 1;
    #1 check("async_rst", read_data, 16'd0);
    @(negedge clk);
    reset = 0;
    idle();
    #1;
    rdr(4'd2);
    check("rst_reg", read_data, 16'd0);
    wr(4'd2, 16'd9);
    rdr(4'd2);
    check("post_wr", read_data, 16'd9);
    pop(4'd2);
    check("rst_sp", read_data, 16'd9);
    rdr(4'd2);
    check("rst_sp_reg", read_data, 16'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
